// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared memory-size encodings and helpers for the MIPS pipeline
package mips_pkg;

  localparam logic [1:0] MEM_BYTE  = 2'b00;
  localparam logic [1:0] MEM_HALF  = 2'b01;
  localparam logic [1:0] MEM_WORD  = 2'b10;
  localparam logic [1:0] MEM_DWORD = 2'b11;

  localparam int DEF_REG_ADDR_W = 6;

  function automatic logic [3:0] size_to_bytes(input logic [1:0] mem_size);
    return 4'd1 << mem_size;
  endfunction

endpackage

// File: rtl/ex_mem_lane_gen.sv
// rtl/ex_mem_lane_gen.sv - combinational byte-enable, store replication and alignment check
module ex_mem_lane_gen
  import mips_pkg::*;
#(
  parameter int  DATA_W = 32,
  localparam int BE_W   = DATA_W / 8,
  localparam int OFS_W  = $clog2(BE_W)
) (
  input  logic [OFS_W-1:0]  ofs,
  input  logic [1:0]        size,
  input  logic              rd,
  input  logic              wr,
  input  logic              valid,
  input  logic [DATA_W-1:0] store_data,
  output logic [BE_W-1:0]   byte_en,
  output logic [DATA_W-1:0] data_rep,
  output logic              misaligned
);

  logic [3:0]      nbytes;
  logic [3:0]      ofs_ext;
  logic            size_bad;
  logic            access;
  logic [BE_W-1:0] lane_mask;

  always_comb begin
    nbytes    = size_to_bytes(size);
    ofs_ext   = 4'(ofs);
    // a doubleword access cannot be served by a 32-bit datapath
    size_bad  = (size == MEM_DWORD) && (DATA_W == 32);
    access    = valid & (rd | wr);
    misaligned = access & (size_bad | ((ofs_ext & (nbytes - 4'd1)) != 4'd0));
    lane_mask = '0;
    for (int i = 0; i < BE_W; i++) lane_mask[i] = (i < int'(nbytes));
    byte_en   = (access & ~misaligned) ? (lane_mask << ofs) : '0;
    data_rep  = '0;
    for (int i = 0; i < BE_W; i++)
      data_rep[8*i +: 8] = store_data[8*(i & (int'(nbytes) - 1)) +: 8];
  end

endmodule

// File: rtl/ex_mem_stage_reg.sv
// rtl/ex_mem_stage_reg.sv - EX/MEM pipeline register with stall, flush and lane logic
module ex_mem_stage_reg
  import mips_pkg::*;
#(
  parameter int  DATA_W     = 32,
  parameter int  REG_ADDR_W = DEF_REG_ADDR_W,
  localparam int BE_W       = DATA_W / 8,
  localparam int OFS_W      = $clog2(BE_W)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  valid_in,
  input  logic [DATA_W-1:0]     alu_result_in,
  input  logic [REG_ADDR_W-1:0] wb_reg_in,
  input  logic [DATA_W-1:0]     store_data_in,
  input  logic                  reg_write_in,
  input  logic                  mem_read_in,
  input  logic                  mem_write_in,
  input  logic [1:0]            mem_size_in,
  input  logic                  mem_unsigned_in,
  output logic                  valid_out,
  output logic [DATA_W-1:0]     alu_result_out,
  output logic [REG_ADDR_W-1:0] wb_reg_out,
  output logic [DATA_W-1:0]     store_data_out,
  output logic [BE_W-1:0]       byte_en_out,
  output logic                  reg_write_out,
  output logic                  mem_read_out,
  output logic                  mem_write_out,
  output logic [1:0]            mem_size_out,
  output logic                  mem_unsigned_out,
  output logic                  misaligned_out,
  output logic                  fwd_valid_out
);

  logic [BE_W-1:0]   lane_be;
  logic [DATA_W-1:0] lane_data;
  logic              lane_mis;
  logic              ctl_ok;

  ex_mem_lane_gen #(.DATA_W(DATA_W)) u_lane_gen (
    .ofs        (alu_result_in[OFS_W-1:0]),
    .size       (mem_size_in),
    .rd         (mem_read_in),
    .wr         (mem_write_in),
    .valid      (valid_in),
    .store_data (store_data_in),
    .byte_en    (lane_be),
    .data_rep   (lane_data),
    .misaligned (lane_mis)
  );

  // a misaligned access keeps valid so the exception unit can claim it
  assign ctl_ok = valid_in & ~lane_mis;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_out        <= 1'b0;
      alu_result_out   <= '0;
      wb_reg_out       <= '0;
      store_data_out   <= '0;
      byte_en_out      <= '0;
      reg_write_out    <= 1'b0;
      mem_read_out     <= 1'b0;
      mem_write_out    <= 1'b0;
      mem_size_out     <= 2'b00;
      mem_unsigned_out <= 1'b0;
      misaligned_out   <= 1'b0;
    end else if (flush) begin
      valid_out        <= 1'b0;
      byte_en_out      <= '0;
      reg_write_out    <= 1'b0;
      mem_read_out     <= 1'b0;
      mem_write_out    <= 1'b0;
      mem_size_out     <= 2'b00;
      mem_unsigned_out <= 1'b0;
      misaligned_out   <= 1'b0;
    end else if (!stall) begin
      valid_out        <= valid_in;
      alu_result_out   <= alu_result_in;
      wb_reg_out       <= wb_reg_in;
      store_data_out   <= lane_data;
      byte_en_out      <= lane_be;
      reg_write_out    <= ctl_ok & reg_write_in;
      mem_read_out     <= ctl_ok & mem_read_in;
      mem_write_out    <= ctl_ok & mem_write_in;
      mem_size_out     <= valid_in ? mem_size_in : 2'b00;
      mem_unsigned_out <= valid_in & mem_unsigned_in;
      misaligned_out   <= lane_mis;
    end
  end

  assign fwd_valid_out = valid_out & reg_write_out & ~mem_read_out & (wb_reg_out != '0);

endmodule

// File: tb/tb_ex_mem_stage_reg.sv
// tb/tb_ex_mem_stage_reg.sv - scoreboard bench for ex_mem_stage_reg at DATA_W=32
module tb_ex_mem_stage_reg;

  logic        clk = 1'b0;
  logic        rst_n, stall, flush, valid_in;
  logic [31:0] alu_result_in, store_data_in;
  logic [5:0]  wb_reg_in;
  logic        reg_write_in, mem_read_in, mem_write_in, mem_unsigned_in;
  logic [1:0]  mem_size_in;
  logic        valid_out, reg_write_out, mem_read_out, mem_write_out;
  logic        mem_unsigned_out, misaligned_out, fwd_valid_out;
  logic [31:0] alu_result_out, store_data_out;
  logic [5:0]  wb_reg_out;
  logic [3:0]  byte_en_out;
  logic [1:0]  mem_size_out;

  typedef struct packed {
    logic        v;
    logic [31:0] alu;
    logic [5:0]  wb;
    logic [31:0] sd;
    logic [3:0]  be;
    logic        rw, mr, mw;
    logic [1:0]  sz;
    logic        uns, mis;
  } exp_t;

  exp_t st;
  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  ex_mem_stage_reg #(.DATA_W(32), .REG_ADDR_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .valid_in(valid_in),
    .alu_result_in(alu_result_in), .wb_reg_in(wb_reg_in), .store_data_in(store_data_in),
    .reg_write_in(reg_write_in), .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
    .mem_size_in(mem_size_in), .mem_unsigned_in(mem_unsigned_in),
    .valid_out(valid_out), .alu_result_out(alu_result_out), .wb_reg_out(wb_reg_out),
    .store_data_out(store_data_out), .byte_en_out(byte_en_out),
    .reg_write_out(reg_write_out), .mem_read_out(mem_read_out), .mem_write_out(mem_write_out),
    .mem_size_out(mem_size_out), .mem_unsigned_out(mem_unsigned_out),
    .misaligned_out(misaligned_out), .fwd_valid_out(fwd_valid_out)
  );

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic compare_all(input string tag, input exp_t e);
    logic fwd;
    fwd = e.v & e.rw & ~e.mr & (e.wb != 6'd0);
    chk_eq({tag, ".valid"}, 64'(valid_out), 64'(e.v));
    chk_eq({tag, ".alu"}, 64'(alu_result_out), 64'(e.alu));
    chk_eq({tag, ".wb"}, 64'(wb_reg_out), 64'(e.wb));
    chk_eq({tag, ".sdata"}, 64'(store_data_out), 64'(e.sd));
    chk_eq({tag, ".be"}, 64'(byte_en_out), 64'(e.be));
    chk_eq({tag, ".rw"}, 64'(reg_write_out), 64'(e.rw));
    chk_eq({tag, ".mr"}, 64'(mem_read_out), 64'(e.mr));
    chk_eq({tag, ".mw"}, 64'(mem_write_out), 64'(e.mw));
    chk_eq({tag, ".size"}, 64'(mem_size_out), 64'(e.sz));
    chk_eq({tag, ".uns"}, 64'(mem_unsigned_out), 64'(e.uns));
    chk_eq({tag, ".mis"}, 64'(misaligned_out), 64'(e.mis));
    chk_eq({tag, ".fwd"}, 64'(fwd_valid_out), 64'(fwd));
  endtask

  function automatic exp_t model_load();
    exp_t e;
    int   nb;
    logic acc;
    nb  = (mem_size_in == 2'd0) ? 1 : (mem_size_in == 2'd1) ? 2 : (mem_size_in == 2'd2) ? 4 : 8;
    acc = valid_in & (mem_read_in | mem_write_in);
    e.mis = acc & ((mem_size_in == 2'd3) || ((alu_result_in % nb) != 0));
    e.be  = 4'b0000;
    if (acc && !e.mis) begin
      case (mem_size_in)
        2'd0:    e.be = 4'b0001 << alu_result_in[1:0];
        2'd1:    e.be = 4'b0011 << alu_result_in[1:0];
        default: e.be = 4'b1111;
      endcase
    end
    case (mem_size_in)
      2'd0:    e.sd = {4{store_data_in[7:0]}};
      2'd1:    e.sd = {2{store_data_in[15:0]}};
      default: e.sd = store_data_in;
    endcase
    e.v   = valid_in;
    e.alu = alu_result_in;
    e.wb  = wb_reg_in;
    e.rw  = valid_in & ~e.mis & reg_write_in;
    e.mr  = valid_in & ~e.mis & mem_read_in;
    e.mw  = valid_in & ~e.mis & mem_write_in;
    e.sz  = valid_in ? mem_size_in : 2'b00;
    e.uns = valid_in & mem_unsigned_in;
    return e;
  endfunction

  task automatic tick(input string tag);
    exp_t nxt;
    nxt = st;
    if (flush) begin
      nxt.v = 0; nxt.be = 0; nxt.rw = 0; nxt.mr = 0; nxt.mw = 0;
      nxt.sz = 0; nxt.uns = 0; nxt.mis = 0;
    end else if (!stall) begin
      nxt = model_load();
    end
    st = nxt;
    sb.push_back(nxt);
    @(posedge clk);
    #1;
    compare_all(tag, sb.pop_front());
  endtask

  task automatic set_in(input logic v, input logic [31:0] a, input logic [5:0] wb,
                        input logic [31:0] d, input logic rw, input logic rd, input logic wr,
                        input logic [1:0] sz, input logic uns);
    valid_in = v; alu_result_in = a; wb_reg_in = wb; store_data_in = d;
    reg_write_in = rw; mem_read_in = rd; mem_write_in = wr;
    mem_size_in = sz; mem_unsigned_in = uns;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
    set_in(1, 32'h1234_5678, 6'd3, 32'hFFFF_FFFF, 1, 0, 0, 2'd2, 0);
    st = '0;
    #3;
    sb.push_back(st);
    compare_all("reset", sb.pop_front());
    @(negedge clk);
    rst_n = 1'b1;

    set_in(1, 32'h0000_1004, 6'd0, 32'hDEAD_BEEF, 0, 0, 1, 2'd2, 0);
    tick("sw");
    set_in(1, 32'h0000_1003, 6'd0, 32'h0000_00A5, 0, 0, 1, 2'd0, 0);
    tick("sb");
    set_in(1, 32'h0000_1001, 6'd7, 32'h0, 1, 1, 0, 2'd1, 0);
    tick("lh_mis");
    set_in(1, 32'h0000_1006, 6'd8, 32'h0000_BEEF, 0, 0, 1, 2'd1, 0);
    tick("sh_hi");
    set_in(1, 32'h0000_2000, 6'd9, 32'h0, 1, 1, 0, 2'd3, 1);
    tick("ld_on32");

    set_in(1, 32'h0000_3008, 6'd10, 32'h0, 1, 1, 0, 2'd2, 0);
    tick("lw");
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_in(1, 32'h0000_4000 + 32'(i * 4), 6'(11 + i), 32'h5555_0000 + 32'(i), 1, 0, 1, 2'd2, 0);
      tick("stall");
    end
    flush = 1'b1;
    tick("flush_stall");
    stall = 1'b0; flush = 1'b0;

    set_in(1, 32'h0000_0042, 6'd0, 32'h0, 1, 0, 0, 2'd2, 0);
    tick("alu_r0");
    set_in(1, 32'h0000_0042, 6'd5, 32'h0, 1, 0, 0, 2'd2, 0);
    tick("alu_r5");
    set_in(1, 32'h0000_0040, 6'd5, 32'h0, 1, 1, 0, 2'd2, 0);
    tick("load_r5");
    set_in(0, 32'h0000_0043, 6'd5, 32'h0000_1234, 1, 1, 1, 2'd1, 1);
    tick("bubble");

    set_in(1, 32'h0000_0100, 6'd6, 32'h0, 1, 0, 0, 2'd2, 0);
    tick("pre_rst");
    #2;
    rst_n = 1'b0;
    #1;
    st = '0;
    sb.push_back(st);
    compare_all("async_rst", sb.pop_front());
    @(negedge clk);
    rst_n = 1'b1;
    set_in(1, 32'h0000_0202, 6'd12, 32'h0000_CAFE, 0, 0, 1, 2'd1, 0);
    tick("post_rst");

    for (int i = 0; i < 60; i++) begin
      stall = ($urandom_range(0, 5) == 0);
      flush = ($urandom_range(0, 9) == 0);
      set_in(1'($urandom_range(0, 4) != 0), $urandom, 6'($urandom_range(0, 3)), $urandom,
             1'($urandom), 1'($urandom), 1'($urandom), 2'($urandom_range(0, 3)), 1'($urandom));
      tick("rand");
    end
    stall = 1'b0; flush = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
